// File: rtl/pc_sequencer.sv
// Instruction issue sequencer: fetches from a program ROM addressed by the pc block, handles WAIT/HALT/MUL.
// Optional macro MUL_STALL_EN: MUL takes a two-cycle RUN->STALL->RUN path instead of issuing in one cycle.
module pc_sequencer #(
   parameter int Psize = 6,
   parameter int Isize = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic [Psize-1:0] PCout,
   output logic [Psize-1:0] prog_addr,
   input  logic [Isize-1:0] prog_data,
   output logic             PCincr,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [Isize-1:0] instr_out,
   output logic             instr_valid,
   output logic             halted
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_STALL = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_WAIT = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   state_t           state_q, state_d;
   logic [Isize-1:0] instr_q, instr_d;
   logic             valid_q, valid_d;
   logic             halted_q, halted_d;
   logic             issue;
   logic [2:0]       opcode;

   assign opcode    = prog_data[Isize-1:Isize-3];
   assign prog_addr = PCout;

   always_comb begin
      state_d  = state_q;
      issue    = 1'b0;
      PCincr   = 1'b0;
      in_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (go) state_d = S_RUN;
         end
         S_RUN: begin
            case (opcode)
               OP_WAIT: begin
                  // Stay on this instruction until the external handshake arrives.
                  in_ready = 1'b1;
                  if (in_valid) begin
                     issue  = 1'b1;
                     PCincr = 1'b1;
                  end
               end
               OP_HALT: begin
                  issue   = 1'b1;
                  state_d = S_HALT;
               end
`ifdef MUL_STALL_EN
               OP_MUL: begin
                  state_d = S_STALL;
               end
`endif
               default: begin
                  issue  = 1'b1;
                  PCincr = 1'b1;
               end
            endcase
         end
         S_STALL: begin
            // Second cycle of a MUL; only reachable when the stall build is selected.
            issue   = 1'b1;
            PCincr  = 1'b1;
            state_d = S_RUN;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      instr_d  = issue ? prog_data : instr_q;
      valid_d  = issue;
      halted_d = (state_d == S_HALT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         instr_q  <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
      end
   end

   assign instr_out   = instr_q;
   assign instr_valid = valid_q;
   assign halted      = halted_q;

endmodule
